// File: rtl/gabor_kernel_bank.sv
// -----------------------------------------------------------------------------
// gabor_kernel_bank
//
// Writable coefficient store for the 2D Gabor convolution datapath. Holds
// NBANKS kernels of KSIZE x KSIZE IEEE-754 single-precision taps in a
// flip-flop array. Coefficients are never interpreted, only moved bit-exact.
//
// Three access paths share the array:
//   * write port   : one coefficient per cycle; illegal writes are dropped and
//                    flagged with a one-cycle wr_err pulse.
//   * read port    : registered random access, latency 1, rd_valid pulse.
//   * stream port  : plays a whole kernel out tap-by-tap (row-major) over a
//                    valid/ready handshake, ending with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   wr_en, wr_bank, wr_addr, wr_data   coefficient write
//   wr_err                             write rejected (one cycle after wr_en)
//   rd_en, rd_bank, rd_addr            random read request
//   rd_data, rd_valid                  read result, valid one cycle after rd_en
//   start, start_bank                  begin streaming a kernel
//   busy                               stream in progress
//   coef_valid, coef_ready             stream handshake
//   coef_data, coef_idx, coef_last     current beat
//   done                               one-cycle pulse after the last beat
// -----------------------------------------------------------------------------
module gabor_kernel_bank #(
    parameter  int KSIZE  = 3,
    parameter  int NBANKS = 4,
    parameter  int DW     = 32,
    localparam int NTAPS  = KSIZE * KSIZE,
    localparam int TAPW   = (NTAPS  > 1) ? $clog2(NTAPS)  : 1,
    localparam int BANKW  = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             wr_en,
    input  logic [BANKW-1:0] wr_bank,
    input  logic [TAPW-1:0]  wr_addr,
    input  logic [DW-1:0]    wr_data,
    output logic             wr_err,

    input  logic             rd_en,
    input  logic [BANKW-1:0] rd_bank,
    input  logic [TAPW-1:0]  rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,

    input  logic             start,
    input  logic [BANKW-1:0] start_bank,
    output logic             busy,
    output logic             coef_valid,
    input  logic             coef_ready,
    output logic [DW-1:0]    coef_data,
    output logic [TAPW-1:0]  coef_idx,
    output logic             coef_last,
    output logic             done
);

    localparam logic [TAPW-1:0] LAST_IDX = TAPW'(NTAPS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state;
    logic [BANKW-1:0] stream_bank;
    logic [DW-1:0]    mem [NBANKS][NTAPS];

    // Default kernel for the 3x3 configuration: bank 0 ships with a usable
    // Gabor kernel so the datapath produces sensible output straight from reset.
    function automatic logic [DW-1:0] reset_value(input int bank, input int tap);
        logic [31:0] v;
        v = '0;
        if (KSIZE == 3 && bank == 0) begin
            case (tap)
                0:       v = 32'h3BA3D70A;
                1:       v = 32'h372A7EF9;
                2:       v = 32'hB2C2A8EB;
                3:       v = 32'h33B4C4DA;
                4:       v = 32'h32F5C28F;
                5:       v = 32'h2AB61E1A;
                6:       v = 32'hA9655C0E;
                7:       v = 32'h24B41C8F;
                8:       v = 32'h215EF96B;
                default: v = '0;
            endcase
        end
        return DW'(v);
    endfunction

    // -------------------------------------------------------------------------
    // Write qualification
    // -------------------------------------------------------------------------
    logic wr_in_range;
    logic wr_hits_stream;
    logic wr_ok;
    logic rd_in_range;

    // NOTE: every signal driven here gets a value on every path through the
    // block before any condition; a missed default would infer a latch.
    always_comb begin
        wr_in_range    = (int'(wr_addr) < NTAPS) && (int'(wr_bank) < NBANKS);
        // The kernel being streamed must stay stable for the whole burst.
        wr_hits_stream = busy && (wr_bank == stream_bank);
        wr_ok          = wr_en && wr_in_range && !wr_hits_stream;
        rd_in_range    = (int'(rd_addr) < NTAPS) && (int'(rd_bank) < NBANKS);
    end

    // -------------------------------------------------------------------------
    // Coefficient storage
    // -------------------------------------------------------------------------
    // NOTE: this array is deliberately reset. It is built from flip-flops, not
    // a RAM macro, so reset restores the shipped default kernel; a RAM-based
    // store would have to be left without a reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int t = 0; t < NTAPS; t++) begin
                    mem[b][t] <= reset_value(b, t);
                end
            end
        end else if (wr_ok) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    // -------------------------------------------------------------------------
    // Random-access read: registered, latency 1. Because the array update is
    // also a clocked non-blocking assignment, a same-cycle write to the same
    // entry is not yet visible and the read returns the old value.
    // -------------------------------------------------------------------------
    // NOTE: clocked state is always assigned with <=, so every register in the
    // design samples the values from before the edge, independent of the
    // order in which the always_ff blocks happen to be evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[rd_bank][rd_addr] : '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stream FSM. All stream outputs are registered; the next tap is fetched
    // from the array on the handshake edge so beats flow at one per cycle.
    // -------------------------------------------------------------------------
    logic [TAPW-1:0] next_idx;

    assign next_idx = coef_idx + TAPW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stream_bank <= '0;
            busy        <= 1'b0;
            coef_valid  <= 1'b0;
            coef_data   <= '0;
            coef_idx    <= '0;
            coef_last   <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Starts naming a non-existent bank are silently dropped.
                    if (start && (int'(start_bank) < NBANKS)) begin
                        state       <= STREAM;
                        stream_bank <= start_bank;
                        busy        <= 1'b1;
                        coef_valid  <= 1'b1;
                        coef_idx    <= '0;
                        coef_data   <= mem[start_bank][0];
                        coef_last   <= (NTAPS == 1);
                    end
                end

                STREAM: begin
                    // coef_valid is high for the whole STREAM state, so the
                    // handshake reduces to coef_ready. With ready low every
                    // beat output simply holds.
                    if (coef_ready) begin
                        if (coef_idx == LAST_IDX) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            coef_valid <= 1'b0;
                            coef_last  <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            coef_idx  <= next_idx;
                            coef_data <= mem[stream_bank][next_idx];
                            coef_last <= (next_idx == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gabor_kernel_bank.sv
// -----------------------------------------------------------------------------
// tb_gabor_kernel_bank
//
// Directed bench for gabor_kernel_bank at default parameters (3x3 taps,
// 4 banks, 32-bit coefficients). A small table of expected bank contents is
// kept by the bench and updated only for writes it expects to be accepted.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gabor_kernel_bank;

    localparam int NTAPS = 9;
    localparam int TAPW  = 4;
    localparam int BANKW = 2;
    localparam int DW    = 32;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [BANKW-1:0] wr_bank;
    logic [TAPW-1:0]  wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_err;
    logic             rd_en;
    logic [BANKW-1:0] rd_bank;
    logic [TAPW-1:0]  rd_addr;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             start;
    logic [BANKW-1:0] start_bank;
    logic             busy;
    logic             coef_valid;
    logic             coef_ready;
    logic [DW-1:0]    coef_data;
    logic [TAPW-1:0]  coef_idx;
    logic             coef_last;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [4][NTAPS];
    bit          toggle_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    gabor_kernel_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .start      (start),
        .start_bank (start_bank),
        .busy       (busy),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_defaults();
        for (int b = 0; b < 4; b++)
            for (int t = 0; t < NTAPS; t++)
                model[b][t] = 32'h0;
        model[0][0] = 32'h3BA3D70A;
        model[0][1] = 32'h372A7EF9;
        model[0][2] = 32'hB2C2A8EB;
        model[0][3] = 32'h33B4C4DA;
        model[0][4] = 32'h32F5C28F;
        model[0][5] = 32'h2AB61E1A;
        model[0][6] = 32'hA9655C0E;
        model[0][7] = 32'h24B41C8F;
        model[0][8] = 32'h215EF96B;
    endtask

    // One write cycle; wr_err is checked on the following cycle.
    task automatic do_write(input logic [1:0] bank, input logic [3:0] addr,
                            input logic [31:0] data, input logic exp_err);
        wr_en = 1'b1; wr_bank = bank; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++;
        if (wr_err !== exp_err) begin
            failures++;
            $display("FAIL wr_err bank %0d addr %0d: got %b expected %b", bank, addr, wr_err, exp_err);
        end
    endtask

    task automatic do_read(input logic [1:0] bank, input logic [3:0] addr,
                           input logic [31:0] exp_data);
        rd_en = 1'b1; rd_bank = bank; rd_addr = addr;
        @(posedge clk); #1;
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
            failures++;
            $display("FAIL read bank %0d addr %0d: got valid=%b data=%h expected valid=1 data=%h",
                     bank, addr, rd_valid, rd_data, exp_data);
        end
    endtask

    // Pulse start; on return the first beat is expected to be on the bus.
    task automatic start_stream(input logic [1:0] bank);
        coef_ready = 1'b0;
        start = 1'b1; start_bank = bank;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || coef_valid !== 1'b1 || coef_idx !== 4'd0) begin
            failures++;
            $display("FAIL stream_entry bank %0d: got busy=%b valid=%b idx=%0d expected busy=1 valid=1 idx=0",
                     bank, busy, coef_valid, coef_idx);
        end
    endtask

    // Accept all nine beats of an active stream, checking every cycle
    // (held beats included), then the done pulse and return to idle.
    task automatic drain_stream(input int bank, input bit toggle);
        int beats = 0;
        int cyc   = 0;
        int exp_cycles;
        exp_cycles = toggle ? 17 : 9;
        while (beats < NTAPS && cyc < 200) begin
            checks++;
            if (coef_valid !== 1'b1 || busy !== 1'b1 || coef_idx !== TAPW'(beats) ||
                coef_data !== model[bank][beats] || coef_last !== (beats == NTAPS - 1)) begin
                failures++;
                $display("FAIL beat bank %0d cycle %0d: got valid=%b busy=%b idx=%0d data=%h last=%b expected valid=1 busy=1 idx=%0d data=%h last=%b",
                         bank, cyc, coef_valid, busy, coef_idx, coef_data, coef_last,
                         beats, model[bank][beats], (beats == NTAPS - 1));
            end
            coef_ready = toggle ? toggle_pat[cyc % 4] : 1'b1;
            @(posedge clk); #1;
            if (coef_ready) beats++;
            cyc++;
        end
        coef_ready = 1'b0;
        checks++;
        if (cyc != exp_cycles) begin
            failures++;
            $display("FAIL stream_length bank %0d: got %0d cycles expected %0d", bank, cyc, exp_cycles);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || coef_valid !== 1'b0 || coef_last !== 1'b0) begin
            failures++;
            $display("FAIL stream_end bank %0d: got done=%b busy=%b valid=%b last=%b expected done=1 busy=0 valid=0 last=0",
                     bank, done, busy, coef_valid, coef_last);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse bank %0d: got done=%b busy=%b expected done=0 busy=0", bank, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
        start = 1'b0; start_bank = '0; coef_ready = 1'b0;
        load_defaults();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_err, rd_valid, busy, coef_valid, coef_last, done} !== 6'b0 ||
            rd_data !== 32'h0 || coef_data !== 32'h0 || coef_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs: got wr_err=%b rd_valid=%b busy=%b valid=%b last=%b done=%b rd_data=%h coef_data=%h idx=%0d expected all 0",
                     wr_err, rd_valid, busy, coef_valid, coef_last, done, rd_data, coef_data, coef_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_default_stream();
        start_stream(2'd0);
        drain_stream(0, 1'b0);
    endtask

    task automatic test_write_read();
        do_write(2'd2, 4'd4, 32'h3F800000, 1'b0);
        model[2][4] = 32'h3F800000;
        do_read(2'd2, 4'd4, 32'h3F800000);
        // rd_valid drops, rd_data holds
        @(posedge clk); #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h3F800000) begin
            failures++;
            $display("FAIL read_hold: got valid=%b data=%h expected valid=0 data=3f800000", rd_valid, rd_data);
        end
        // same-cycle write and read of one entry returns the old value
        wr_en = 1'b1; wr_bank = 2'd3; wr_addr = 4'd0; wr_data = 32'h11111111;
        rd_en = 1'b1; rd_bank = 2'd3; rd_addr = 4'd0;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL read_during_write: got valid=%b data=%h wr_err=%b expected valid=1 data=00000000 wr_err=0",
                     rd_valid, rd_data, wr_err);
        end
        model[3][0] = 32'h11111111;
        do_read(2'd3, 4'd0, 32'h11111111);
        start_stream(2'd2);
        drain_stream(2, 1'b0);
    endtask

    task automatic test_ready_toggle();
        start_stream(2'd0);
        drain_stream(0, 1'b1);
    endtask

    task automatic test_busy_protect();
        do_write(2'd1, 4'd0, 32'h12345678, 1'b0);
        do_write(2'd1, 4'd8, 32'h87654321, 1'b0);
        model[1][0] = 32'h12345678;
        model[1][8] = 32'h87654321;
        start_stream(2'd1);
        do_write(2'd1, 4'd0, 32'hDEADBEEF, 1'b1);
        // the error is a single-cycle pulse
        checks++;
        @(posedge clk); #1;
        if (wr_err !== 1'b0) begin
            failures++;
            $display("FAIL wr_err_pulse: got %b expected 0", wr_err);
        end
        do_write(2'd3, 4'd2, 32'hCAFEF00D, 1'b0);
        model[3][2] = 32'hCAFEF00D;
        // start while busy must not restart or switch banks
        start = 1'b1; start_bank = 2'd2;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || coef_idx !== 4'd0 || coef_data !== 32'h12345678) begin
            failures++;
            $display("FAIL start_while_busy: got busy=%b idx=%0d data=%h expected busy=1 idx=0 data=12345678",
                     busy, coef_idx, coef_data);
        end
        drain_stream(1, 1'b0);
        do_read(2'd3, 4'd2, 32'hCAFEF00D);
        do_read(2'd1, 4'd0, 32'h12345678);
    endtask

    task automatic test_bad_write();
        do_write(2'd0, 4'd9, 32'hFFFFFFFF, 1'b1);
        do_write(2'd0, 4'd15, 32'hFFFFFFFF, 1'b1);
        do_read(2'd0, 4'd12, 32'h0);
        do_read(2'd0, 4'd0, 32'h3BA3D70A);
        do_read(2'd0, 4'd8, 32'h215EF96B);
    endtask

    task automatic test_reset_mid_stream();
        start_stream(2'd0);
        coef_ready = 1'b1;
        for (int c = 0; c < 20 && coef_idx !== 4'd5; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (coef_idx !== 4'd5 || coef_valid !== 1'b1) begin
            failures++;
            $display("FAIL reach_beat5: got idx=%0d valid=%b expected idx=5 valid=1", coef_idx, coef_valid);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({wr_err, rd_valid, busy, coef_valid, coef_last, done} !== 6'b0 ||
            rd_data !== 32'h0 || coef_data !== 32'h0 || coef_idx !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b valid=%b done=%b idx=%0d data=%h rd_data=%h expected all 0",
                     busy, coef_valid, done, coef_idx, coef_data, rd_data);
        end
        coef_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_defaults();
        do_read(2'd2, 4'd4, 32'h0);
        do_read(2'd3, 4'd2, 32'h0);
        do_read(2'd1, 4'd0, 32'h0);
        start_stream(2'd0);
        drain_stream(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_write_read();
        test_ready_toggle();
        test_busy_protect();
        test_bad_write();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/gabor_kernel_bank.md
Name: gabor_kernel_bank

Overview:
- Parametrised, writable coefficient store for the 2D Gabor convolution datapath.
- Holds NBANKS kernels (one per orientation/scale) of KSIZE×KSIZE IEEE-754 single-precision taps.
- Supports two ways of reading:
  - streams a selected kernel tap-by-tap to the MAC engine over a valid/ready handshake;
  - supports runtime coefficient loading and a registered random-access read port.

Parameters:
- KSIZE, 3: kernel side length; NTAPS = KSIZE*KSIZE.
- NBANKS, 4: number of kernel banks.
- DW, 32: coefficient width in bits (IEEE-754 single).
- TAPW, derived: max(1, $clog2(NTAPS)); 4 at defaults.
- BANKW, derived: max(1, $clog2(NBANKS)); 2 at defaults.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  coefficient write strobe.
- wr_bank  in  BANKW  bank to write.
- wr_addr  in  TAPW  tap index (row-major) to write.
- wr_data  in  DW  coefficient value.
- wr_err  out  1  one-cycle pulse: write rejected.
- rd_en  in  1  random-read strobe.
- rd_bank  in  BANKW  bank to read.
- rd_addr  in  TAPW  tap index to read.
- rd_data  out  DW  read result.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- start  in  1  begin streaming a kernel.
- start_bank  in  BANKW  bank to stream.
- busy  out  1  stream in progress.
- coef_valid  out  1  coef_data valid.
- coef_ready  in  1  downstream accepts beat.
- coef_data  out  DW  streamed coefficient.
- coef_idx  out  TAPW  tap index of current beat.
- coef_last  out  1  current beat is tap NTAPS-1.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0; FSM returns to IDLE.
  - Storage: bank 0 taps 0..8 = 3BA3D70A, 372A7EF9, B2C2A8EB, 33B4C4DA, 32F5C28F, 2AB61E1A, A9655C0E, 24B41C8F, 215EF96B (only when KSIZE==3).
  - All other entries reset to 0.
- Storage is a flip-flop array, NBANKS×NTAPS×DW.
- Write:
  - Committed at the clock edge where wr_en=1.
  - Rejected, with wr_err=1 on the next cycle, if any of:
    - wr_addr ≥ NTAPS;
    - wr_bank ≥ NBANKS;
    - busy=1 and wr_bank equals the latched stream bank.
  - A rejected write leaves storage unchanged.
- Random read:
  - Latency 1: rd_data and rd_valid are registered, one cycle after rd_en.
  - Out-of-range address or bank returns 0 with rd_valid=1.
  - A write and a read to the same entry in the same cycle: the read returns the old value.
  - rd_data holds its value until the next rd_en.
- Stream FSM, states IDLE and STREAM:
  - IDLE, start=1, start_bank<NBANKS:
    - latch the bank, set idx=0, go to STREAM;
    - next cycle: busy=1, coef_valid=1, coef_idx=0, coef_data=tap 0.
  - IDLE, start with start_bank ≥ NBANKS: ignored.
  - STREAM, coef_valid & coef_ready:
    - if idx < NTAPS-1, idx increments and the next beat appears on the following cycle (one beat per cycle under continuous ready).
    - if idx == NTAPS-1 (coef_last=1), next cycle: coef_valid=0, busy=0, done=1, state IDLE.
  - STREAM, coef_ready=0: coef_data, coef_idx, coef_last held stable.
  - start while busy: ignored, including during the last-beat handshake cycle.
  - A new start is accepted no earlier than the done cycle, so back-to-back kernels have one idle cycle between them.
  - coef_last = (coef_idx == NTAPS-1) & coef_valid.
- Reset asserted mid-stream:
  - aborts immediately; coef_valid, busy, done go to 0;
  - storage returns to reset contents.
- No arithmetic is performed on coefficients; values pass through bit-exact.

Test Plan:
- Reset, start with start_bank=0, coef_ready held 1:
  - nine beats on consecutive cycles, idx 0..8, data 3BA3D70A … 215EF96B;
  - coef_last on idx 8; done one cycle later; busy low after.
- Write bank 2 tap 4 = 3F800000, then rd_en bank 2 addr 4:
  - rd_valid with rd_data=3F800000 one cycle later;
  - stream bank 2: beat idx 4 = 3F800000, other beats 0.
- Stream bank 0 with coef_ready toggling 1,0,0,1…:
  - each beat is held while ready=0;
  - exactly nine handshakes; sequence unchanged.
- During a bank 1 stream:
  - write to bank 1 → wr_err pulse, contents unchanged;
  - write to bank 3 → accepted, no wr_err;
  - start pulse mid-stream → ignored.
- Write with wr_addr=9 or wr_bank invalid: wr_err=1, no storage change. Read addr 12: rd_data=0.
- Assert rst_n low at beat idx 5:
  - outputs 0 asynchronously;
  - bank 2 is back to 0;
  - a new stream of bank 0 yields the default nine values.
